rgb_dither: RTL and testbench
=============================

# rgb_dither

Ordered-dither output stage that sits directly downstream of the monochrome/colour-filter stage in the video path. It takes 8-bit-per-channel RGB plus syncs and blanking, and reduces each channel to OUTW bits for the board DAC using a 4x4 Bayer threshold matrix. The matrix phase can optionally rotate every frame (temporal dither). Syncs and blanking are delayed to match the pixel latency.

## Interface
- OUTW, default 6: output bits per channel, legal range 1..7; D = 8-OUTW bits are dropped.
- clk  in  1  system video clock
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  pixel clock enable; all state advances only when ce=1
- dither_en  in  1  1 = Bayer dither, 0 = plain truncation
- temporal_en  in  1  1 = rotate matrix phase per frame
- ri, gi, bi  in  8 each  filtered RGB pixel
- hsync_n, vsync_n, blank_n  in  1 each  active-low sync/blank aligned with the RGB input
- ro, go, bo  out  OUTW each  dithered RGB
- hsync_n_o, vsync_n_o, blank_n_o  out  1 each  sync/blank delayed to match ro/go/bo

## Operation
- Pixel coordinates:
  - x (2-bit) clears while blank_n=0 and increments on each ce with blank_n=1.
  - y (2-bit) increments on the blank_n 1→0 edge.
  - y clears on the vsync_n 1→0 edge.
  - frame (2-bit) increments on the vsync_n 1→0 edge and wraps 3→0.
  - Edges are detected on ce-qualified samples.
  - If vsync and an end-of-line edge fall on the same ce, clear y; do not increment it.
- Matrix index:
  - row = y ^ (temporal_en ? frame : 0)
  - col = x ^ (temporal_en ? {frame[0],frame[1]} : 0)
- Bayer thresholds t, row-major:
  - row 0: 0 8 2 10
  - row 1: 12 4 14 6
  - row 2: 3 11 1 9
  - row 3: 15 7 13 5
- Bias per channel: bias = t<<(D-4) if D≥4, else t>>(4-D). This guarantees bias < 2^D.
- Output per channel:
  - sum = {1'b0,in} + bias (9 bits).
  - out = sum[8] ? all-ones : sum[7:D].
  - Black (0) always maps to 0; 255 always maps to all-ones.
- dither_en=0: out = in[7:D], with the same latency.
- While the delayed blank_n_o=0: ro/go/bo are forced to 0.
- dither_en and temporal_en are sampled per pixel in stage 1. Changing them mid-line takes effect on the next pixel, with no glitch on syncs.

## Timing
- Two-stage pipeline, both stages advance only on ce:
  - Stage 1 registers RGB, sync/blank and t.
  - Stage 2 registers the adder/saturate result and sync/blank.
- Latency: exactly 2 ce-qualified cycles from input to output, identical for pixels and syncs. With ce=0, all outputs hold.
- Reset (asynchronous, rst_n=0):
  - ro/go/bo = 0
  - hsync_n_o = vsync_n_o = blank_n_o = 1
  - x = y = frame = 0; edge-detect history = 1 (no spurious edge on release)
- Reset mid-frame: the counters restart from 0. Matrix alignment recovers at the next vsync_n falling edge; the output has no X or undefined cycles.
- Wrap-around: x and y wrap naturally modulo 4. Lines and frames of any length are legal.

## Structure
- The shared video package/include holds the BAYER4 threshold constant (16×4 bits) and the bias-shift function of D, so that future OSD/scaler stages can reuse them.
- One natural combinational sub-module, dither_channel: inputs 8-bit value, 4-bit t and dither_en; output is the OUTW-bit saturated result. It is instantiated three times.
- The top module holds the counters, edge detectors and the pipeline registers.

## Test plan
All scenarios use OUTW=6, D=2, so bias = t>>2.
- Static dither, dither_en=1, temporal_en=0, constant 8'h81 on all channels, first active line after vsync:
  - outputs at x=0..3 are 32,32,32,32 (t=0,8,2,10 give bias 0,2,0,2)
  - line y=1, x=0 (t=12, bias 3) gives 33
  - line y=1, x=2 (t=14) gives 33
- Saturation and black: input 8'hFF gives 63 at every x/y; input 8'h00 gives 0 at every x/y; dither_en=0 with 8'h83 gives 32.
- Temporal dither: temporal_en=1 after one vsync (frame=1), pixel (0,0) maps to row 1, col 2, t=14, so 8'h81 gives 33; after four vsyncs the pattern repeats frame 0.
- Latency and ce: random ce duty cycle; ro and all sync outputs match a reference model delayed by exactly 2 ce pulses; outputs hold while ce=0; ro=0 whenever blank_n_o=0.
- Reset: assert rst_n mid-line; check outputs immediately go to 0 with syncs at 1; release; check no y/frame increment until a genuine falling edge.
- Simultaneous events: end-of-line and vsync edges on the same ce leave y=0 and advance frame by 1.

Source files
------------

// File: rtl/rgb_dither_pkg.sv
// rgb_dither_pkg: shared video constants and helpers.
//   BAYER4       - 4x4 ordered-dither threshold matrix, row-major, 4 bits per entry
//   bayer_lookup - threshold for a (row, col) matrix position
//   bayer_bias   - scales a 4-bit threshold into the D dropped bits of a channel
package rgb_dither_pkg;

    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    function automatic logic [3:0] bayer_lookup(input logic [1:0] row, input logic [1:0] col);
        return BAYER4[{row, col}];
    endfunction

    // Result is always below 2^d, so adding it can carry at most one bit past the
    // kept field; the channel saturates on that carry.
    function automatic logic [7:0] bayer_bias(input logic [3:0] t, input int unsigned d);
        logic [7:0] t8;
        t8 = {4'b0000, t};
        if (d >= 4) begin
            return t8 << (d - 4);
        end else begin
            return t8 >> (4 - d);
        end
    endfunction

endpackage

// File: rtl/rgb_dither_channel.sv
// dither_channel: combinational ordered dither of one 8-bit colour channel.
//   value     in  8     input channel value
//   t         in  4     Bayer threshold for this pixel
//   dither_en in  1     1 = add scaled threshold before truncating, 0 = plain truncation
//   result    out OUTW  saturated, truncated channel value
module dither_channel
    import rgb_dither_pkg::*;
#(
    parameter int unsigned OUTW = 6
) (
    input  logic [7:0]      value,
    input  logic [3:0]      t,
    input  logic            dither_en,
    output logic [OUTW-1:0] result
);

    localparam int unsigned D = 8 - OUTW;

    logic [7:0] bias;
    logic [8:0] sum;

    always_comb begin
        bias = dither_en ? bayer_bias(t, D) : 8'd0;
        sum  = {1'b0, value} + {1'b0, bias};
        // A carry out of bit 7 means the rounded value overflowed the kept field.
        if (sum[8]) begin
            result = '1;
        end else begin
            result = OUTW'(sum >> D);
        end
    end

endmodule

// File: rtl/rgb_dither.sv
// rgb_dither: two-stage ordered-dither output stage for the board DAC.
//   clk, rst_n                    clock, asynchronous active-low reset
//   ce                            pixel clock enable; all state advances only when high
//   dither_en, temporal_en        Bayer dither enable, per-frame matrix rotation enable
//   ri, gi, bi                    8-bit RGB input pixel
//   hsync_n, vsync_n, blank_n     active-low syncs/blank aligned with the RGB input
//   ro, go, bo                    OUTW-bit dithered RGB, forced to 0 while blanked
//   hsync_n_o, vsync_n_o, blank_n_o  syncs/blank delayed by the same 2 ce pulses
module rgb_dither
    import rgb_dither_pkg::*;
#(
    parameter int unsigned OUTW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            dither_en,
    input  logic            temporal_en,
    input  logic [7:0]      ri,
    input  logic [7:0]      gi,
    input  logic [7:0]      bi,
    input  logic            hsync_n,
    input  logic            vsync_n,
    input  logic            blank_n,
    output logic [OUTW-1:0] ro,
    output logic [OUTW-1:0] go,
    output logic [OUTW-1:0] bo,
    output logic            hsync_n_o,
    output logic            vsync_n_o,
    output logic            blank_n_o
);

    // Pixel coordinate state and edge-detect history.
    logic [1:0] x_q, y_q, frame_q;
    logic       blank_prev_q, vsync_prev_q;

    logic       eol, vs_fall;
    logic [1:0] row, col;
    logic [3:0] t_d;

    always_comb begin
        eol     = blank_prev_q & ~blank_n;
        vs_fall = vsync_prev_q & ~vsync_n;
        row     = y_q ^ (temporal_en ? frame_q : 2'b00);
        col     = x_q ^ (temporal_en ? {frame_q[0], frame_q[1]} : 2'b00);
        t_d     = bayer_lookup(row, col);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= 2'd0;
            y_q          <= 2'd0;
            frame_q      <= 2'd0;
            // History starts high so releasing reset never fakes a falling edge.
            blank_prev_q <= 1'b1;
            vsync_prev_q <= 1'b1;
        end else if (ce) begin
            x_q <= blank_n ? x_q + 2'd1 : 2'd0;
            // Frame start wins over end-of-line when both land on the same pixel.
            if (vs_fall) begin
                y_q     <= 2'd0;
                frame_q <= frame_q + 2'd1;
            end else if (eol) begin
                y_q <= y_q + 2'd1;
            end
            blank_prev_q <= blank_n;
            vsync_prev_q <= vsync_n;
        end
    end

    // Stage 1: input pixel, threshold and per-pixel dither enable.
    logic [7:0] r1_q, g1_q, b1_q;
    logic [3:0] t1_q;
    logic       den1_q, hs1_q, vs1_q, bl1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q   <= 8'd0;
            g1_q   <= 8'd0;
            b1_q   <= 8'd0;
            t1_q   <= 4'd0;
            den1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            bl1_q  <= 1'b1;
        end else if (ce) begin
            r1_q   <= ri;
            g1_q   <= gi;
            b1_q   <= bi;
            t1_q   <= t_d;
            den1_q <= dither_en;
            hs1_q  <= hsync_n;
            vs1_q  <= vsync_n;
            bl1_q  <= blank_n;
        end
    end

    logic [OUTW-1:0] r_res, g_res, b_res;

    dither_channel #(.OUTW(OUTW)) u_ch_r (
        .value     (r1_q),
        .t         (t1_q),
        .dither_en (den1_q),
        .result    (r_res)
    );

    dither_channel #(.OUTW(OUTW)) u_ch_g (
        .value     (g1_q),
        .t         (t1_q),
        .dither_en (den1_q),
        .result    (g_res)
    );

    dither_channel #(.OUTW(OUTW)) u_ch_b (
        .value     (b1_q),
        .t         (t1_q),
        .dither_en (den1_q),
        .result    (b_res)
    );

    // Stage 2: saturated result, blanked pixels forced to black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro        <= '0;
            go        <= '0;
            bo        <= '0;
            hsync_n_o <= 1'b1;
            vsync_n_o <= 1'b1;
            blank_n_o <= 1'b1;
        end else if (ce) begin
            ro        <= bl1_q ? r_res : '0;
            go        <= bl1_q ? g_res : '0;
            bo        <= bl1_q ? b_res : '0;
            hsync_n_o <= hs1_q;
            vsync_n_o <= vs1_q;
            blank_n_o <= bl1_q;
        end
    end

endmodule

// File: tb/tb_rgb_dither.sv
// tb_rgb_dither: directed and randomized check of rgb_dither (OUTW=6) against a
// cycle-level reference model of pixel coordinates, Bayer dithering and a 2-pulse delay.
module tb_rgb_dither;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       dither_en, temporal_en;
    logic [7:0] ri, gi, bi;
    logic       hsync_n, vsync_n, blank_n;
    logic [5:0] ro, go, bo;
    logic       hsync_n_o, vsync_n_o, blank_n_o;

    rgb_dither #(.OUTW(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .dither_en   (dither_en),
        .temporal_en (temporal_en),
        .ri          (ri),
        .gi          (gi),
        .bi          (bi),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .blank_n     (blank_n),
        .ro          (ro),
        .go          (go),
        .bo          (bo),
        .hsync_n_o   (hsync_n_o),
        .vsync_n_o   (vsync_n_o),
        .blank_n_o   (blank_n_o)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int r, g, b;
        bit hs, vs, bl;
    } exp_t;

    int   bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    exp_t q [$];
    exp_t cur;
    int   mx, my, mframe;
    bit   bl_prev, vs_prev;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t idle_out();
        exp_t e;
        e.r = 0; e.g = 0; e.b = 0; e.hs = 1; e.vs = 1; e.bl = 1;
        return e;
    endfunction

    // D = 2 for OUTW = 6: bias = t/4, result = (v + bias)/4 clipped to 63.
    function automatic int chan(input int v, input int bias);
        int s;
        s = v + bias;
        return (s > 255) ? 63 : s / 4;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mframe = 0;
        bl_prev = 1; vs_prev = 1;
        q.delete();
        q.push_back(idle_out());
        cur = idle_out();
    endtask

    task automatic model_step(input int r, g, b, input bit hs, vs, bl, de, te);
        exp_t e;
        int   row, col, bias;
        row  = my ^ (te ? mframe : 0);
        col  = mx ^ (te ? (((mframe & 1) << 1) | ((mframe >> 1) & 1)) : 0);
        bias = de ? bay[row][col] / 4 : 0;
        e.r  = bl ? chan(r, bias) : 0;
        e.g  = bl ? chan(g, bias) : 0;
        e.b  = bl ? chan(b, bias) : 0;
        e.hs = hs; e.vs = vs; e.bl = bl;
        q.push_back(e);
        cur = q.pop_front();
        if (vs_prev && !vs) begin
            my     = 0;
            mframe = (mframe + 1) % 4;
        end else if (bl_prev && !bl) begin
            my = (my + 1) % 4;
        end
        mx      = bl ? (mx + 1) % 4 : 0;
        bl_prev = bl;
        vs_prev = vs;
    endtask

    task automatic check_outputs();
        chk("ro", 8'(ro), 8'(cur.r));
        chk("go", 8'(go), 8'(cur.g));
        chk("bo", 8'(bo), 8'(cur.b));
        chk("hsync_n_o", 8'(hsync_n_o), 8'(cur.hs));
        chk("vsync_n_o", 8'(vsync_n_o), 8'(cur.vs));
        chk("blank_n_o", 8'(blank_n_o), 8'(cur.bl));
    endtask

    // One clock: inputs change at negedge, DUT samples at posedge, outputs checked at negedge.
    task automatic drive(input bit c, input logic [7:0] r, g, b,
                         input bit hs, vs, bl, de, te);
        ce = c; ri = r; gi = g; bi = b;
        hsync_n = hs; vsync_n = vs; blank_n = bl;
        dither_en = de; temporal_en = te;
        @(posedge clk);
        if (c) model_step(int'(r), int'(g), int'(b), hs, vs, bl, de, te);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        vsync_n = 1'b1; blank_n = 1'b1; hsync_n = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_ro", 8'(ro), 8'd0);
        chk("rst_go", 8'(go), 8'd0);
        chk("rst_bo", 8'(bo), 8'd0);
        chk("rst_hs", 8'(hsync_n_o), 8'd1);
        chk("rst_vs", 8'(vsync_n_o), 8'd1);
        chk("rst_bl", 8'(blank_n_o), 8'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic vsync_pulse();
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
    endtask

    // Four active pixels at x=0..3 then blanking; o[i] is the ro seen for pixel i.
    task automatic run_line(input logic [7:0] v, input bit de, te, output logic [3:0][5:0] o);
        for (int i = 0; i < 4; i++) begin
            drive(1, v, v, v, 1, 1, 1, de, te);
            if (i > 0) o[i-1] = ro;
        end
        drive(1, 0, 0, 0, 0, 1, 0, de, te);
        o[3] = ro;
        drive(1, 0, 0, 0, 0, 1, 0, de, te);
    endtask

    task automatic chk_line(input string tag, input logic [3:0][5:0] o,
                            input int e0, e1, e2, e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) chk(tag, 8'(o[i]), 8'(e[i]));
    endtask

    logic [3:0][5:0] obs;
    bit de_r, te_r;

    initial begin
        ce = 1'b0; dither_en = 1'b1; temporal_en = 1'b0;
        ri = 8'd0; gi = 8'd0; bi = 8'd0;
        hsync_n = 1'b1; vsync_n = 1'b1; blank_n = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        // Static dither, first two lines after a vsync.
        vsync_pulse();
        run_line(8'h81, 1, 0, obs);
        chk_line("static_y0", obs, 32, 32, 32, 32);
        run_line(8'h81, 1, 0, obs);
        chk_line("static_y1", obs, 33, 32, 33, 32);

        // Saturation, black and plain truncation over all rows.
        vsync_pulse();
        for (int l = 0; l < 4; l++) begin
            run_line(8'hFF, 1, 0, obs);
            chk_line("white", obs, 63, 63, 63, 63);
        end
        for (int l = 0; l < 4; l++) begin
            run_line(8'h00, 1, 0, obs);
            chk_line("black", obs, 0, 0, 0, 0);
        end
        run_line(8'h83, 0, 0, obs);
        chk_line("trunc", obs, 32, 32, 32, 32);

        // Temporal dither: frame 1, then frame 0 after 3 more, then frame 1 again.
        do_reset();
        vsync_pulse();
        run_line(8'h81, 1, 1, obs);
        chk_line("temporal_f1", obs, 33, 32, 33, 32);
        for (int k = 0; k < 3; k++) vsync_pulse();
        run_line(8'h81, 1, 1, obs);
        chk_line("temporal_f0", obs, 32, 32, 32, 32);
        vsync_pulse();
        run_line(8'h81, 1, 1, obs);
        chk_line("temporal_f1b", obs, 33, 32, 33, 32);

        // Reset mid-line: counters restart, no frame/line advance on release.
        drive(1, 8'h81, 8'h81, 8'h81, 1, 1, 1, 1, 1);
        drive(1, 8'h81, 8'h81, 8'h81, 1, 1, 1, 1, 1);
        do_reset();
        run_line(8'h81, 1, 1, obs);
        chk_line("post_reset", obs, 32, 32, 32, 32);

        // End-of-line and vsync falling on the same pixel: y stays 0, frame advances.
        drive(1, 8'h81, 8'h81, 8'h81, 1, 1, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
        run_line(8'h81, 1, 1, obs);
        chk_line("simultaneous", obs, 33, 32, 33, 32);

        // Randomized lines, blanking, vsyncs, ce duty cycle and mode toggles.
        de_r = 1; te_r = 0;
        for (int ln = 0; ln < 150; ln++) begin
            int alen, blen, vstart;
            bit vline;
            alen   = $urandom_range(1, 9);
            blen   = $urandom_range(1, 5);
            vline  = ($urandom_range(0, 5) == 0);
            vstart = $urandom_range(0, blen - 1);
            for (int p = 0; p < alen; p++) begin
                if ($urandom_range(0, 7) == 0) de_r = ~de_r;
                if ($urandom_range(0, 7) == 0) te_r = ~te_r;
                drive($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      1, 1, 1, de_r, te_r);
            end
            if (ln == 70) do_reset();
            for (int j = 0; j < blen; j++) begin
                drive($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      (j != 0), !(vline && j >= vstart), 0, de_r, te_r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
